reg_file_2r1w: RTL and testbench
================================

# reg_file_2r1w

Parametrised integer register file for the core's decode/writeback stages: two combinational read ports, one synchronous write port, write-to-read forwarding, a hardwired-zero register 0, and a per-register busy scoreboard for in-flight results. Storage has no per-bit reset. After reset, a clear sequencer sweeps every register to zero, and `init_done` holds off the pipeline until the sweep finishes.

## Interface
- `XLEN`, default 32: data width of each register.
- `NUM_REGS`, default 32: number of architectural registers, including register 0. Legal range is 2..256.
- `ADDR_W`, default `$clog2(NUM_REGS)`: address width.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `rs1_addr`, `rs2_addr`, input, ADDR_W: read addresses.
- `rs1_data`, `rs2_data`, output, XLEN: read data, combinational.
- `rs1_busy`, `rs2_busy`, output, 1: the addressed register awaits a writeback. Combinational.
- `wr_en`, input, 1: writeback strobe.
- `wr_addr`, input, ADDR_W: writeback address.
- `wr_data`, input, XLEN: writeback data.
- `rsv_en`, input, 1: issue strobe. Marks `rsv_addr` busy.
- `rsv_addr`, input, ADDR_W: destination register being issued.
- `init_done`, output, 1: the clear sweep is complete and the block is accepting writes and reservations.

## Operation
- State machine states are CLEAR and READY.
  - `rst` high forces CLEAR, sets the clear counter to 1, zeroes all busy bits and drops `init_done` to 0.
  - In CLEAR, each rising edge writes 0 to register[counter] and increments the counter.
  - The edge that writes register NUM_REGS-1 moves the state to READY.
  - READY holds until the next `rst`.
- Register 0 is never stored.
  - Reads of address 0 return 0 and busy 0.
  - Writes and reservations to address 0 are ignored.
- An address ≥ NUM_REGS (non-power-of-two depth) behaves like address 0.
- While in CLEAR:
  - `wr_en` and `rsv_en` are ignored.
  - `rsX_data` returns 0.
  - `rsX_busy` returns 0.
- Read path in READY, per port:
  - If `wr_en`=1, `wr_addr`==`rsX_addr` and the address is nonzero, `rsX_data` = `wr_data` (forwarded) and `rsX_busy` = 0.
  - Otherwise, `rsX_data` = register[`rsX_addr`] and `rsX_busy` = busy[`rsX_addr`].
- Write path in READY: `wr_en`=1 stores `wr_data` and clears busy[`wr_addr`] at the rising edge.
- Scoreboard in READY: `rsv_en`=1 sets busy[`rsv_addr`] at the rising edge.
- Simultaneous events:
  - `wr_en` and `rsv_en` to the same address in the same cycle: data is written and busy ends at 1. The reservation is a newer producer and wins.
  - `wr_en` and `rsv_en` to different addresses: both take effect.
  - `rsv_en` on an already-busy register: it stays busy, with no error.
  - `wr_en` on a non-busy register: data is written and busy stays 0.
- The two read ports are fully independent and may use the same address.

## Timing
- Reset values:
  - `init_done`=0.
  - All busy bits 0, so `rs1_busy`=`rs2_busy`=0.
  - `rs1_data`=`rs2_data`=0.
- Sweep latency: `init_done` rises immediately after the (NUM_REGS-1)th rising edge with `rst` low. That is 31 edges at the default size.
- Asserting `rst` mid-sweep or in READY asynchronously returns the block to CLEAR with the counter at 1. The full sweep restarts after deassertion. Register contents are undefined until the sweep rewrites them.
- Read latency is 0 cycles (combinational from address, and from the write port when forwarding).
- Write latency: data is visible from storage on the cycle after the write edge, and via forwarding in the write cycle itself.
- Busy set latency is 1 cycle: busy reads 1 starting the cycle after the `rsv_en` edge.
- Busy clear latency is 0 cycles at the read port (forwarded). The stored bit clears at the edge.
- Counter width is ADDR_W+1 so the terminal compare does not wrap when NUM_REGS is a power of two.

## Test plan
- Reset and sweep:
  - Stimulus: pulse `rst`, then count edges until `init_done` rises, reading every address during the sweep and after it.
  - Required: `init_done` rises after exactly 31 edges. All reads return 0x0 during the sweep and after it.
- Write, read-back and forwarding:
  - Stimulus: in READY, write 0xDEADBEEF to register 5 while `rs1_addr`=5 in the same cycle.
  - Required: `rs1_data`=0xDEADBEEF in that cycle and on the next cycle. `rs2_addr`=5 also returns 0xDEADBEEF.
- Register 0:
  - Stimulus: write 0x12345678 to address 0 and reserve address 0, then read address 0 on both ports.
  - Required: data=0x0 and busy=0 on both ports.
- Scoreboard:
  - Stimulus: reserve register 7, check `rs1_busy` on the next cycle, then write 0xA5 to register 7 in the cycle after.
  - Required: busy reads 1 on the cycle after the reservation. It reads 0 in the write cycle itself, and `rs1_data`=0xA5 from that cycle onward.
- Simultaneous reserve and write to the same address:
  - Stimulus: drive `rsv_en` and `wr_en` both to register 9 with data 0x55 in one cycle.
  - Required: on the next cycle `rs1_data`=0x55 and `rs1_busy`=1.
- Reset mid-operation:
  - Stimulus: from READY with register 3=0x77 and busy[3]=1, assert `rst` for 1 cycle.
  - Required: `init_done` drops to 0 immediately and busy[3] reads 0. Register 3 reads 0x0 after `init_done` re-rises, 31 edges later.
  - Additionally, a `wr_en` pulse issued during the sweep has no effect.

Source files
------------

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_2r1w
// Brief    : Integer register file with two combinational read ports, one
//            write port, write-to-read forwarding, hardwired-zero register 0,
//            a per-register busy scoreboard and a post-reset clear sweep.
// Revision : 1.0
// ============================================================================
module reg_file_2r1w #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              init_done
);

    localparam logic              c_ST_CLEAR = 1'b0;
    localparam logic              c_ST_READY = 1'b1;
    localparam logic [ADDR_W:0]   c_CNT_LAST = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(NUM_REGS);

    logic              r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_init_done;

    logic              w_ready;
    logic              w_wr_go;
    logic              w_rsv_go;

    logic [XLEN-1:0]   w_mem  [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] w_busy;

    logic [ADDR_W-1:0] w_rs_addr [2];
    logic [XLEN-1:0]   w_rs_data [2];
    logic              w_rs_busy [2];

    assign w_ready  = (r_state == c_ST_READY);
    assign w_wr_go  = w_ready & wr_en;
    assign w_rsv_go = w_ready & rsv_en;

    // ------------------------------------------------------------------------
    // Clear sequencer: one register per edge, counter starts at 1 because
    // register 0 has no storage.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_CLEAR;
            r_cnt       <= (ADDR_W+1)'(1);
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state     <= c_ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                c_ST_READY: begin
                    r_state     <= c_ST_READY;
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= c_ST_CLEAR;
                    r_cnt       <= (ADDR_W+1)'(1);
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign init_done = r_init_done;

    // ------------------------------------------------------------------------
    // Storage and scoreboard, one slice per architectural register 1..N-1.
    // Addresses that match no slice (0 or beyond depth) have no effect.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic            w_clr_hit;
            logic            w_wr_hit;
            logic            w_rsv_hit;
            logic [XLEN-1:0] r_data;
            logic            r_busy;

            assign w_clr_hit = (r_state == c_ST_CLEAR) && (r_cnt == (ADDR_W+1)'(gi));
            assign w_wr_hit  = w_wr_go  && (wr_addr  == ADDR_W'(gi));
            assign w_rsv_hit = w_rsv_go && (rsv_addr == ADDR_W'(gi));

            always_ff @(posedge clk) begin
                if (w_clr_hit) begin
                    r_data <= '0;
                end else if (w_wr_hit) begin
                    r_data <= wr_data;
                end
            end

            // A reservation in the same cycle as a writeback is the newer
            // producer, so it takes priority over the clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_busy <= 1'b0;
                end else if (w_rsv_hit) begin
                    r_busy <= 1'b1;
                end else if (w_wr_hit) begin
                    r_busy <= 1'b0;
                end
            end

            assign w_mem[gi]  = r_data;
            assign w_busy[gi] = r_busy;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    assign w_rs_addr[0] = rs1_addr;
    assign w_rs_addr[1] = rs2_addr;

    generate
        for (genvar gp = 0; gp < 2; gp++) begin : g_port
            logic            w_valid;
            logic            w_fwd;
            logic [XLEN-1:0] w_stored;
            logic            w_stored_busy;

            assign w_valid = (w_rs_addr[gp] != '0) &&
                             ({1'b0, w_rs_addr[gp]} < c_DEPTH);

            always_comb begin
                w_stored      = '0;
                w_stored_busy = 1'b0;
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (w_rs_addr[gp] == ADDR_W'(i)) begin
                        w_stored      = w_mem[i];
                        w_stored_busy = w_busy[i];
                    end
                end
            end

            assign w_fwd = w_wr_go && w_valid && (wr_addr == w_rs_addr[gp]);

            assign w_rs_data[gp] = (!w_ready || !w_valid) ? '0 :
                                   (w_fwd ? wr_data : w_stored);
            assign w_rs_busy[gp] = w_ready && w_valid && !w_fwd && w_stored_busy;
        end
    endgenerate

    assign rs1_data = w_rs_data[0];
    assign rs2_data = w_rs_data[1];
    assign rs1_busy = w_rs_busy[0];
    assign rs2_busy = w_rs_busy[1];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_2r1w
// Brief    : Directed self-checking bench for reg_file_2r1w at default size.
// Revision : 1.0
// ============================================================================
module tb_reg_file_2r1w;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              init_done;

    int total;
    int bad;
    int edges;

    reg_file_2r1w #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Sweep until init_done, starting from a falling edge with rst low.
    // Optionally fires a stray write at a given edge to prove it is ignored.
    task automatic sweep(input int wr_at, input logic [ADDR_W-1:0] wr_reg);
        edges = 0;
        for (int e = 1; e <= 40; e++) begin
            rs1_addr = ADDR_W'(e % NUM_REGS);
            rs2_addr = ADDR_W'((NUM_REGS - 1) - (e % NUM_REGS));
            wr_en    = (e == wr_at);
            wr_addr  = wr_reg;
            wr_data  = 32'hBAD0_BAD0;
            rsv_en   = (e == wr_at);
            rsv_addr = wr_reg;
            #1;
            chk("sweep_rs1_data", rs1_data, 32'h0);
            chk("sweep_rs2_data", rs2_data, 32'h0);
            chk("sweep_busy", {30'b0, rs1_busy, rs2_busy}, 32'h0);
            @(posedge clk);
            #1;
            if (init_done) begin
                edges = e;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        chk("sweep_edges", edges, 31);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;

        // Reset state
        #3;
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", {30'b0, rs1_busy, rs2_busy}, 0);
        chk("rst_data", rs1_data | rs2_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sweep, with a stray write/reserve to reg 4 after it was cleared
        sweep(10, 5'd4);

        // Every address reads zero and not busy after the sweep
        for (int a = 0; a < NUM_REGS; a++) begin
            rs1_addr = ADDR_W'(a);
            rs2_addr = ADDR_W'(NUM_REGS - 1 - a);
            #1;
            chk("post_rs1_data", rs1_data, 0);
            chk("post_rs2_data", rs2_data, 0);
            chk("post_busy", {30'b0, rs1_busy, rs2_busy}, 0);
            @(negedge clk);
        end

        // Write with same-cycle forwarding on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        chk("fwd_rs1", rs1_data, 32'hDEAD_BEEF);
        chk("fwd_rs2", rs2_data, 32'hDEAD_BEEF);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("stored_rs1", rs1_data, 32'hDEAD_BEEF);
        chk("stored_rs2", rs2_data, 32'hDEAD_BEEF);
        chk("stored_busy", rs1_busy, 0);
        @(negedge clk);

        // Register 0 ignores writes and reservations
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        chk("r0_fwd_data", rs1_data | rs2_data, 0);
        @(negedge clk);
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        chk("r0_rs1_data", rs1_data, 0);
        chk("r0_rs2_data", rs2_data, 0);
        chk("r0_busy", {30'b0, rs1_busy, rs2_busy}, 0);
        @(negedge clk);

        // Scoreboard set then cleared by writeback
        rsv_en = 1'b1; rsv_addr = 5'd7; rs1_addr = 5'd7;
        #1;
        chk("sb_busy_same_cycle", rs1_busy, 0);
        @(negedge clk);
        rsv_en = 1'b0;
        #1;
        chk("sb_busy_set", rs1_busy, 1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_00A5;
        #1;
        chk("sb_busy_fwd_clear", rs1_busy, 0);
        chk("sb_data_fwd", rs1_data, 32'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("sb_busy_cleared", rs1_busy, 0);
        chk("sb_data_stored", rs1_data, 32'hA5);
        @(negedge clk);

        // Same-address reserve and write: reservation wins
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        rs1_addr = 5'd9;
        #1;
        chk("same_fwd_busy", rs1_busy, 0);
        @(negedge clk);
        rsv_en = 1'b0; wr_en = 1'b0;
        #1;
        chk("same_data", rs1_data, 32'h55);
        chk("same_busy", rs1_busy, 1);
        @(negedge clk);

        // Re-reserve an already busy register
        rsv_en = 1'b1; rsv_addr = 5'd9;
        @(negedge clk);
        rsv_en = 1'b0;
        #1;
        chk("rereserve_busy", rs1_busy, 1);
        @(negedge clk);

        // Different-address reserve and write in one cycle
        rsv_en = 1'b1; rsv_addr = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h1111_2222;
        @(negedge clk);
        rsv_en = 1'b0; wr_en = 1'b0;
        rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        chk("diff_rsv_busy", rs1_busy, 1);
        chk("diff_wr_busy", rs2_busy, 0);
        chk("diff_wr_data", rs2_data, 32'h1111_2222);
        @(negedge clk);

        // Reset from READY with reg 3 = 0x77 and busy
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        @(negedge clk);
        wr_en = 1'b0;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        @(negedge clk);
        rsv_en = 1'b0;
        rs1_addr = 5'd3;
        #1;
        chk("pre_rst_data", rs1_data, 32'h77);
        chk("pre_rst_busy", rs1_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_busy", rs1_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep(12, 5'd3);
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        chk("after_rst_r3_data", rs1_data, 0);
        chk("after_rst_r3_busy", {30'b0, rs1_busy, rs2_busy}, 0);
        rs1_addr = 5'd5;
        #1;
        chk("after_rst_r5_data", rs1_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
